ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter MDU_LAT, default 4, SHALL set the multiply/divide busy duration in cycles; legal range 1..15.
REQ-002 Parameter LINK_REG, default 31, SHALL set the destination register written by jal.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 id_valid  input  1  SHALL mark that the instruction in ID is valid.
REQ-006 opcode, funct  input  6 each  SHALL carry instruction bits [31:26] and [5:0].
REQ-007 rs, rt, rd  input  5 each  SHALL carry instruction bits [25:21], [20:16] and [15:11].
REQ-008 flush  input  1  SHALL mark a taken branch or jump resolved in EX; it kills the ID instruction.
REQ-009 stall  output  1  SHALL be combinational; when high, PC and IF/ID hold.
REQ-010 mdu_busy  output  1  SHALL be registered; high while a mult/div is in flight.
REQ-011 ex_* outputs (registered ID/EX bundle) SHALL be: ex_valid 1, ex_signext 1, ex_aluop 2, ex_alusrc 1, ex_memread 1, ex_memwrite 1, ex_memtoreg 1, ex_regwrite 1, ex_wreg 5, ex_branch 1, ex_branchne 1, ex_jump 1, ex_jumpr 1, ex_link 1, ex_mdu_start 1, ex_illegal 1.

Function
REQ-012 Decode: lw(23h) signext,aluop 00,alusrc,memread,memtoreg,regwrite,wreg=rt, reads rs.
REQ-013 sw(2Bh) signext, aluop 00, alusrc, memwrite, reads rs, rt.
REQ-014 beq(04h)/bne(05h) signext, aluop 01, branch, branchne=opcode[0], reads rs, rt.
REQ-015 j(02h) aluop 11, jump; jal(03h) additionally link, regwrite, wreg=LINK_REG.
REQ-016 opcode 00h: funct 08h (jr) aluop 11, jump, jumpr, reads rs; funct 18h-1Bh (mult/multu/div/divu) mdu_start, reads rs, rt, no regwrite; funct 10h/12h (mfhi/mflo) regwrite, wreg=rd, mdu-dependent; any other funct aluop 10, regwrite, wreg=rd, reads rs, rt.
REQ-017 opcode 001xxx: signext=~opcode[2], aluop 10, alusrc, regwrite, wreg=rt, reads rs.
REQ-018 Any other opcode: all controls 0, ex_illegal=1.
REQ-019 All signals not listed for an instruction SHALL be 0 (no don't-cares).
REQ-020 regwrite SHALL be forced 0 when wreg=0.
REQ-021 Load-use hazard: stall=1 when id_valid, ex_valid, ex_memread, ex_wreg!=0, and (ex_wreg==rs with rs read, or ex_wreg==rt with rt read).
REQ-022 MDU hazard: stall=1 when id_valid and mdu_busy and ID is mult/div or mfhi/mflo.
REQ-023 stall SHALL be 0 whenever flush=1.
REQ-024 Each edge: if flush, stall or !id_valid, ID/EX loads a bubble (all ex_* 0); else loads the decoded bundle with ex_valid=1.
REQ-025 MDU FSM: states IDLE, BUSY; 4-bit down-counter cnt.
REQ-026 IDLE->BUSY when a mult/div is issued (loaded into ID/EX with ex_valid=1); cnt loads MDU_LAT-1.
REQ-027 BUSY: cnt decrements each cycle; BUSY->IDLE on the edge where cnt==0.
REQ-028 mdu_busy=1 exactly in BUSY, i.e. MDU_LAT cycles after the issue edge.
REQ-029 A killed (flushed) or stalled mult/div SHALL NOT start the FSM.
REQ-030 Latency: decoded bundle visible on ex_* one cycle after ID presentation; stall has zero latency.

Reset
REQ-031 While rst=1 at an edge: all ex_* = 0, mdu_busy=0, FSM=IDLE, cnt=0.
REQ-032 rst SHALL override flush, stall and issue; a mult/div in flight is abandoned.
REQ-033 stall after reset SHALL depend only on current inputs and cleared state (0 with no MDU/load hazard).

Verification
REQ-034 lw $8 then add $9,$8,$1 back-to-back -> stall=1 one cycle, one bubble (ex_valid=0), add issues next cycle with wreg=9, aluop 10.
REQ-035 mult (MDU_LAT=4) then mflo $2 -> mdu_busy high 4 cycles, stall high while mflo waits, mflo issues the cycle mdu_busy falls, wreg=2.
REQ-036 flush=1 with lw in ID and load-use hazard present -> stall=0, ex_valid=0 next cycle, no MDU start.
REQ-037 jal -> ex_jump=1, ex_link=1, ex_regwrite=1, ex_wreg=31; addiu $0,$0,5 -> ex_regwrite=0.
REQ-038 opcode 3Fh -> ex_illegal=1, all other ex controls 0; andi 0Ch -> ex_signext=0.
REQ-039 rst asserted two cycles into a mult -> next cycle mdu_busy=0, ex_valid=0; a following mfhi issues without stall.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: bundle between the ID stage (instruction fields, flush) and the
// ctrl_pipe control unit (stall, mdu_busy, registered ID/EX control bundle).
//   master : drives the ID-stage instruction fields and flush, observes controls
//   slave  : ctrl_pipe itself, consumes ID fields and drives stall / ex_* bundle
interface ctrl_pipe_if;
    // ID-stage instruction and pipeline control
    logic       id_valid;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       flush;

    // Hazard outputs
    logic       stall;
    logic       mdu_busy;

    // Registered ID/EX control bundle
    logic       ex_valid;
    logic       ex_signext;
    logic [1:0] ex_aluop;
    logic       ex_alusrc;
    logic       ex_memread;
    logic       ex_memwrite;
    logic       ex_memtoreg;
    logic       ex_regwrite;
    logic [4:0] ex_wreg;
    logic       ex_branch;
    logic       ex_branchne;
    logic       ex_jump;
    logic       ex_jumpr;
    logic       ex_link;
    logic       ex_mdu_start;
    logic       ex_illegal;

    modport master (
        output id_valid, opcode, funct, rs, rt, rd, flush,
        input  stall, mdu_busy,
        input  ex_valid, ex_signext, ex_aluop, ex_alusrc, ex_memread, ex_memwrite,
        input  ex_memtoreg, ex_regwrite, ex_wreg, ex_branch, ex_branchne, ex_jump,
        input  ex_jumpr, ex_link, ex_mdu_start, ex_illegal
    );

    modport slave (
        input  id_valid, opcode, funct, rs, rt, rd, flush,
        output stall, mdu_busy,
        output ex_valid, ex_signext, ex_aluop, ex_alusrc, ex_memread, ex_memwrite,
        output ex_memtoreg, ex_regwrite, ex_wreg, ex_branch, ex_branchne, ex_jump,
        output ex_jumpr, ex_link, ex_mdu_start, ex_illegal
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: MIPS-style main decoder, hazard unit and ID/EX control register.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ctrl_pipe_if.slave
//          in  id_valid, opcode, funct, rs, rt, rd, flush
//          out stall (combinational), mdu_busy (registered), ex_* (registered)
// Parameters:
//   MDU_LAT  : multiply/divide busy duration in cycles (1..15)
//   LINK_REG : destination register written by jal
module ctrl_pipe #(
    parameter int unsigned MDU_LAT  = 4,
    parameter int unsigned LINK_REG = 31
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_pipe_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic       signext;
        logic [1:0] aluop;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] wreg;
        logic       branch;
        logic       branchne;
        logic       jump;
        logic       jumpr;
        logic       link;
        logic       mdu_start;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {IDLE, BUSY} mdu_state_t;

    ctrl_t      dec;
    logic       reads_rs;
    logic       reads_rt;
    logic       mdu_dep;      // instruction must wait for the MDU (mult/div or mfhi/mflo)

    ctrl_t      ex_d, ex_q;
    mdu_state_t state_q;
    logic [3:0] cnt_q;
    logic       mdu_busy_q;

    logic       load_use;
    logic       mdu_haz;
    logic       stall;
    logic       issue;

    // ---------------- Decode ----------------
    always_comb begin
        dec      = '0;
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        mdu_dep  = 1'b0;
        casez (bus.opcode)
            6'h00: begin
                case (bus.funct)
                    6'h08: begin
                        dec.aluop = 2'b11;
                        dec.jump  = 1'b1;
                        dec.jumpr = 1'b1;
                        reads_rs  = 1'b1;
                    end
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        dec.mdu_start = 1'b1;
                        reads_rs      = 1'b1;
                        reads_rt      = 1'b1;
                        mdu_dep       = 1'b1;
                    end
                    6'h10, 6'h12: begin
                        dec.regwrite = 1'b1;
                        dec.wreg     = bus.rd;
                        mdu_dep      = 1'b1;
                    end
                    default: begin
                        dec.aluop    = 2'b10;
                        dec.regwrite = 1'b1;
                        dec.wreg     = bus.rd;
                        reads_rs     = 1'b1;
                        reads_rt     = 1'b1;
                    end
                endcase
            end
            6'h02: begin
                dec.aluop = 2'b11;
                dec.jump  = 1'b1;
            end
            6'h03: begin
                dec.aluop    = 2'b11;
                dec.jump     = 1'b1;
                dec.link     = 1'b1;
                dec.regwrite = 1'b1;
                dec.wreg     = 5'(LINK_REG);
            end
            6'h04, 6'h05: begin
                dec.signext  = 1'b1;
                dec.aluop    = 2'b01;
                dec.branch   = 1'b1;
                dec.branchne = bus.opcode[0];
                reads_rs     = 1'b1;
                reads_rt     = 1'b1;
            end
            6'b001???: begin
                // andi/ori/xori/lui (opcode[2]=1) zero-extend their immediate
                dec.signext  = ~bus.opcode[2];
                dec.aluop    = 2'b10;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.wreg     = bus.rt;
                reads_rs     = 1'b1;
            end
            6'h23: begin
                dec.signext  = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
                dec.wreg     = bus.rt;
                reads_rs     = 1'b1;
            end
            6'h2B: begin
                dec.signext  = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                reads_rs     = 1'b1;
                reads_rt     = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // $0 is hardwired; a write to it must never be enabled
        if (dec.wreg == 5'd0) begin
            dec.regwrite = 1'b0;
        end
    end

    // ---------------- Hazards ----------------
    always_comb begin
        load_use = bus.id_valid && ex_q.valid && ex_q.memread && (ex_q.wreg != 5'd0) &&
                   (((ex_q.wreg == bus.rs) && reads_rs) || ((ex_q.wreg == bus.rt) && reads_rt));
        mdu_haz  = bus.id_valid && mdu_busy_q && mdu_dep;
        // A flushed ID instruction is dead, so it can never hold the front end
        stall    = !bus.flush && (load_use || mdu_haz);
        issue    = bus.id_valid && !bus.flush && !stall;
        ex_d     = '0;
        if (issue) begin
            ex_d       = dec;
            ex_d.valid = 1'b1;
        end
    end

    // ---------------- ID/EX register and MDU FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q       <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            mdu_busy_q <= 1'b0;
        end else begin
            ex_q <= ex_d;
            case (state_q)
                IDLE: begin
                    if (issue && dec.mdu_start) begin
                        state_q    <= BUSY;
                        cnt_q      <= 4'(MDU_LAT - 1);
                        mdu_busy_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= IDLE;
                        mdu_busy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
            endcase
        end
    end

    assign bus.stall        = stall;
    assign bus.mdu_busy     = mdu_busy_q;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_signext   = ex_q.signext;
    assign bus.ex_aluop     = ex_q.aluop;
    assign bus.ex_alusrc    = ex_q.alusrc;
    assign bus.ex_memread   = ex_q.memread;
    assign bus.ex_memwrite  = ex_q.memwrite;
    assign bus.ex_memtoreg  = ex_q.memtoreg;
    assign bus.ex_regwrite  = ex_q.regwrite;
    assign bus.ex_wreg      = ex_q.wreg;
    assign bus.ex_branch    = ex_q.branch;
    assign bus.ex_branchne  = ex_q.branchne;
    assign bus.ex_jump      = ex_q.jump;
    assign bus.ex_jumpr     = ex_q.jumpr;
    assign bus.ex_link      = ex_q.link;
    assign bus.ex_mdu_start = ex_q.mdu_start;
    assign bus.ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

    localparam int MDU_LAT = 4;

    typedef struct packed {
        bit       valid;
        bit       signext;
        bit [1:0] aluop;
        bit       alusrc;
        bit       memread;
        bit       memwrite;
        bit       memtoreg;
        bit       regwrite;
        bit [4:0] wreg;
        bit       branch;
        bit       branchne;
        bit       jump;
        bit       jumpr;
        bit       link;
        bit       mdu_start;
        bit       illegal;
    } ex_t;

    typedef struct packed {
        ex_t ex;
        bit  busy;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    ctrl_pipe_if bus_if ();

    ctrl_pipe #(.MDU_LAT(MDU_LAT), .LINK_REG(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int  checks   = 0;
    int  failures = 0;
    sb_t sb_q[$];

    // Reference model state: what ID/EX holds now and how many busy cycles remain
    ex_t m_ex  = '0;
    int  m_rem = 0;
    bit  last_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction semantics described per instruction class
    function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       output ex_t e, output bit urs, output bit urt,
                                       output bit waits_mdu);
        e = '0; urs = 0; urt = 0; waits_mdu = 0;
        if (op == 6'h23) begin
            e.signext = 1; e.alusrc = 1; e.memread = 1; e.memtoreg = 1; e.regwrite = 1;
            e.wreg = rt; urs = 1;
        end else if (op == 6'h2B) begin
            e.signext = 1; e.alusrc = 1; e.memwrite = 1; urs = 1; urt = 1;
        end else if (op == 6'h04 || op == 6'h05) begin
            e.signext = 1; e.aluop = 2'b01; e.branch = 1; e.branchne = (op == 6'h05);
            urs = 1; urt = 1;
        end else if (op == 6'h02) begin
            e.aluop = 2'b11; e.jump = 1;
        end else if (op == 6'h03) begin
            e.aluop = 2'b11; e.jump = 1; e.link = 1; e.regwrite = 1; e.wreg = 5'd31;
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            e.signext = (op < 6'h0C); e.aluop = 2'b10; e.alusrc = 1; e.regwrite = 1;
            e.wreg = rt; urs = 1;
        end else if (op == 6'h00) begin
            if (fn == 6'h08) begin
                e.aluop = 2'b11; e.jump = 1; e.jumpr = 1; urs = 1;
            end else if (fn >= 6'h18 && fn <= 6'h1B) begin
                e.mdu_start = 1; urs = 1; urt = 1; waits_mdu = 1;
            end else if (fn == 6'h10 || fn == 6'h12) begin
                e.regwrite = 1; e.wreg = rd; waits_mdu = 1;
            end else begin
                e.aluop = 2'b10; e.regwrite = 1; e.wreg = rd; urs = 1; urt = 1;
            end
        end else begin
            e.illegal = 1;
        end
        if (e.wreg == 0) e.regwrite = 0;
    endfunction

    // One ID cycle: drive inputs, check stall, predict what the next edge leaves in ID/EX
    task automatic step(input bit r, input bit v, input bit fl, input logic [5:0] op,
                        input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d);
        ex_t e;
        bit  urs, urt, wm, lu, md, st, iss;
        @(negedge clk);
        rst = r; bus_if.id_valid = v; bus_if.flush = fl;
        bus_if.opcode = op; bus_if.funct = fn; bus_if.rs = s; bus_if.rt = t; bus_if.rd = d;
        #1;
        ref_decode(op, fn, t, d, e, urs, urt, wm);
        lu = v && m_ex.valid && m_ex.memread && m_ex.wreg != 0 &&
             ((m_ex.wreg == s && urs) || (m_ex.wreg == t && urt));
        md = v && (m_rem > 0) && wm;
        st = !fl && (lu || md);
        chk("stall", bus_if.stall, st);
        last_stall = st;
        if (r) begin
            m_ex = '0; m_rem = 0;
        end else begin
            iss = v && !fl && !st;
            if (iss) begin
                m_ex = e; m_ex.valid = 1;
            end else begin
                m_ex = '0;
            end
            if (iss && e.mdu_start) m_rem = MDU_LAT;
            else if (m_rem > 0) m_rem--;
        end
        sb_q.push_back('{ex: m_ex, busy: (m_rem > 0)});
    endtask

    task automatic nop();
        step(0, 0, 0, 6'h00, 6'h20, 5'd0, 5'd0, 5'd0);
    endtask

    function automatic ex_t sample();
        ex_t a;
        a.valid = bus_if.ex_valid;       a.signext = bus_if.ex_signext;
        a.aluop = bus_if.ex_aluop;       a.alusrc = bus_if.ex_alusrc;
        a.memread = bus_if.ex_memread;   a.memwrite = bus_if.ex_memwrite;
        a.memtoreg = bus_if.ex_memtoreg; a.regwrite = bus_if.ex_regwrite;
        a.wreg = bus_if.ex_wreg;         a.branch = bus_if.ex_branch;
        a.branchne = bus_if.ex_branchne; a.jump = bus_if.ex_jump;
        a.jumpr = bus_if.ex_jumpr;       a.link = bus_if.ex_link;
        a.mdu_start = bus_if.ex_mdu_start; a.illegal = bus_if.ex_illegal;
        return a;
    endfunction

    // Monitor: after every edge the DUT presents a new ID/EX bundle
    always @(posedge clk) begin
        sb_t exp;
        #1;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            chk("ex_bundle", 32'(sample()), 32'(exp.ex));
            chk("mdu_busy", 32'(bus_if.mdu_busy), 32'(exp.busy));
        end
    end

    initial begin
        int n;
        logic [5:0] op, fn;
        logic [4:0] s, t, d;
        bit v, fl, r;
        logic [5:0] ops[14] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                6'h09, 6'h0C, 6'h23, 6'h23, 6'h2B, 6'h3F, 6'h0F};
        logic [5:0] fns[9]  = '{6'h20, 6'h21, 6'h08, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12};

        rst = 1; bus_if.id_valid = 0; bus_if.flush = 0; bus_if.opcode = 0;
        bus_if.funct = 0; bus_if.rs = 0; bus_if.rt = 0; bus_if.rd = 0;
        step(1, 0, 0, 6'h00, 6'h20, 5'd0, 5'd0, 5'd0);
        step(1, 1, 0, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0);
        nop();
        chk("reset_ex_valid", bus_if.ex_valid, 0);
        chk("reset_busy", bus_if.mdu_busy, 0);

        // Load-use: lw $8 ; add $9,$8,$1
        step(0, 1, 0, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0);
        step(0, 1, 0, 6'h00, 6'h20, 5'd8, 5'd1, 5'd9);
        chk("lu_stall", bus_if.stall, 1);
        step(0, 1, 0, 6'h00, 6'h20, 5'd8, 5'd1, 5'd9);
        chk("lu_bubble", bus_if.ex_valid, 0);
        nop();
        chk("lu_add_wreg", bus_if.ex_wreg, 9);
        chk("lu_add_aluop", bus_if.ex_aluop, 2'b10);

        // mult then mflo $2 waits until the MDU is idle
        step(0, 1, 0, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0);
        n = 0;
        do begin
            step(0, 1, 0, 6'h00, 6'h12, 5'd0, 5'd0, 5'd2);
            if (last_stall) n++;
        end while (last_stall && n < 10);
        chk("mdu_stall_cycles", n, MDU_LAT);
        nop();
        chk("mflo_wreg", bus_if.ex_wreg, 2);
        chk("mflo_busy_low", bus_if.mdu_busy, 0);

        // Flush beats a load-use hazard and kills a mult
        step(0, 1, 0, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0);
        step(0, 1, 1, 6'h23, 6'h00, 5'd8, 5'd3, 5'd0);
        chk("flush_no_stall", bus_if.stall, 0);
        step(0, 1, 1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0);
        chk("flush_bubble", bus_if.ex_valid, 0);
        nop();
        chk("flush_no_mdu", bus_if.mdu_busy, 0);

        // jal / addiu $0 / illegal / andi
        step(0, 1, 0, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0);
        step(0, 1, 0, 6'h09, 6'h05, 5'd0, 5'd0, 5'd0);
        chk("jal_link", bus_if.ex_link, 1);
        chk("jal_wreg", bus_if.ex_wreg, 31);
        step(0, 1, 0, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
        chk("addiu0_regwrite", bus_if.ex_regwrite, 0);
        step(0, 1, 0, 6'h0C, 6'h00, 5'd1, 5'd4, 5'd0);
        chk("illegal", bus_if.ex_illegal, 1);
        nop();
        chk("andi_signext", bus_if.ex_signext, 0);
        chk("andi_regwrite", bus_if.ex_regwrite, 1);

        // Reset two cycles into a mult abandons it
        step(0, 1, 0, 6'h00, 6'h1A, 5'd1, 5'd2, 5'd0);
        nop();
        nop();
        step(1, 0, 0, 6'h00, 6'h20, 5'd0, 5'd0, 5'd0);
        step(0, 1, 0, 6'h00, 6'h10, 5'd0, 5'd0, 5'd5);
        chk("rst_busy", bus_if.mdu_busy, 0);
        chk("rst_mfhi_stall", bus_if.stall, 0);
        nop();
        chk("rst_mfhi_wreg", bus_if.ex_wreg, 5);

        // Randomized traffic; a stalled instruction is re-presented like a held IF/ID
        for (int i = 0; i < 2000; i++) begin
            if (!last_stall || $urandom_range(0, 3) == 0) begin
                op = ops[$urandom_range(0, 13)];
                if ($urandom_range(0, 9) == 0) op = 6'($urandom);
                fn = fns[$urandom_range(0, 8)];
                s = 5'($urandom_range(0, 3)); t = 5'($urandom_range(0, 3));
                d = 5'($urandom_range(0, 3));
                v = ($urandom_range(0, 7) != 0);
            end
            fl = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 99) == 0);
            step(r, v, fl, op, fn, s, t, d);
        end

        nop();
        @(posedge clk);
        #2;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
